// File: rtl/reg_exec_pipe.sv
// reg_exec_pipe: issue/execute/writeback pipeline with full forwarding and an iterative shift-add multiply
module reg_exec_pipe #(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_rs1,
  input  logic [N-1:0] in_rs2,
  input  logic [N-1:0] in_rd,
  input  logic [M-1:0] in_imm,
  output logic [N-1:0] a1,
  output logic [N-1:0] a2,
  input  logic [M-1:0] d1,
  input  logic [M-1:0] d2,
  output logic         we3,
  output logic [N-1:0] a3,
  output logic [M-1:0] d3,
  output logic [15:0]  retire_cnt
);
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_LI = 3'd4, OP_MUL = 3'd5;
  logic          ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [2:0]    ex_op_q, ex_op_d;
  logic [N-1:0]  ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic [M-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
  logic [M-1:0]  mul_acc_q, mul_acc_d, wb_res_q, wb_res_d;
  logic [CW-1:0] mul_cnt_q, mul_cnt_d;
  logic [15:0]   retire_q, retire_d;
  logic          ex_done, ex_we, acc, mul_step, wb_fire;
  logic [M-1:0]  mul_part, ex_res, op_a, op_b;
  assign ex_done  = (ex_op_q != OP_MUL) || (mul_cnt_q == CW'(M - 1));
  assign ex_we    = ex_op_q[2:1] != 2'b11;
  assign in_ready = !ex_valid_q || ex_done;
  assign acc      = in_valid && in_ready;
  assign mul_step = ex_valid_q && !ex_done;
  assign wb_fire  = ex_valid_q && ex_done;
  assign a1 = in_rs1;
  assign a2 = in_rs2;
  assign we3 = wb_valid_q && wb_we_q;
  assign a3 = wb_rd_q;
  assign d3 = wb_res_q;
  assign retire_cnt = retire_q;
  // partial product for the current multiplier bit; on the last step it completes the product
  assign mul_part = ex_b_q[mul_cnt_q] ? (ex_a_q << mul_cnt_q) : '0;
  assign ex_res = (ex_op_q == OP_ADD) ? ex_a_q + ex_b_q :
                  (ex_op_q == OP_SUB) ? ex_a_q - ex_b_q :
                  (ex_op_q == OP_AND) ? ex_a_q & ex_b_q :
                  (ex_op_q == OP_OR)  ? ex_a_q | ex_b_q :
                  (ex_op_q == OP_LI)  ? ex_imm_q :
                  (ex_op_q == OP_MUL) ? mul_acc_q + mul_part : '0;
  // EX forward outranks WB so the youngest write to a register wins
  assign op_a = (wb_fire && ex_we && ex_rd_q == in_rs1) ? ex_res :
                (wb_valid_q && wb_we_q && wb_rd_q == in_rs1) ? wb_res_q : d1;
  assign op_b = (wb_fire && ex_we && ex_rd_q == in_rs2) ? ex_res :
                (wb_valid_q && wb_we_q && wb_rd_q == in_rs2) ? wb_res_q : d2;
  always_comb begin
    ex_valid_d = acc || mul_step;
    ex_op_d    = acc ? in_op : ex_op_q;
    ex_rd_d    = acc ? in_rd : ex_rd_q;
    ex_a_d     = acc ? op_a : ex_a_q;
    ex_b_d     = acc ? op_b : ex_b_q;
    ex_imm_d   = acc ? in_imm : ex_imm_q;
    mul_cnt_d  = acc ? '0 : mul_step ? mul_cnt_q + CW'(1) : mul_cnt_q;
    mul_acc_d  = acc ? '0 : mul_step ? mul_acc_q + mul_part : mul_acc_q;
    wb_valid_d = wb_fire;
    wb_we_d    = wb_fire ? ex_we : wb_we_q;
    wb_rd_d    = wb_fire ? ex_rd_q : wb_rd_q;
    wb_res_d   = wb_fire ? ex_res : wb_res_q;
    retire_d   = retire_q + 16'(wb_valid_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      mul_cnt_q  <= '0;
      mul_acc_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_res_q   <= '0;
      retire_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_acc_q  <= mul_acc_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_res_q   <= wb_res_d;
      retire_q   <= retire_d;
    end
  end
endmodule

// File: tb/tb_reg_exec_pipe.sv
// tb_reg_exec_pipe: directed vector table plus hand sequences for multiply stalls and reset abort
module tb_reg_exec_pipe;
  logic       clk = 1'b0, rst_n, in_valid, in_ready, we3;
  logic [2:0] in_op;
  logic [1:0] in_rs1, in_rs2, in_rd, a1, a2, a3;
  logic [3:0] in_imm, d1, d2, d3;
  logic [15:0] retire_cnt;
  logic [3:0] rf [4] = '{default: 4'd0};
  int ncmp = 0, nfail = 0;
  typedef struct {
    logic [2:0] op;
    logic [1:0] rs1, rs2, rd;
    logic [3:0] imm, exp;
  } vec_t;
  vec_t vq[$];
  reg_exec_pipe #(.N(2), .M(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .a1(a1), .a2(a2),
    .d1(d1), .d2(d2), .we3(we3), .a3(a3), .d3(d3), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  assign d1 = rf[a1];
  assign d2 = rf[a2];
  always @(posedge clk) if (we3) rf[a3] <= d3;
  function automatic vec_t mk(logic [2:0] op, logic [1:0] rs1, rs2, rd, logic [3:0] imm, exp);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.exp = exp;
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_imm = v.imm; in_valid = 1'b1;
  endtask
  task automatic run_vecs();
    int n = vq.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        vec_t v = vq[k-2];
        if (v.op < 3'd6) chk($sformatf("wr%0d", k - 2), {we3, a3, d3}, {1'b1, v.rd, v.exp});
        else chk($sformatf("nop_we%0d", k - 2), we3, 0);
      end
      if (k < n) begin
        drive(vq[k]);
        #1;
        chk("in_ready", in_ready, 1);
        chk("rd_addr", {a1, a2}, {vq[k].rs1, vq[k].rs2});
      end else in_valid = 1'b0;
    end
  endtask
  task automatic issue(logic [2:0] op, logic [1:0] rs1, rs2, rd, logic [3:0] imm);
    int w = 0;
    @(negedge clk);
    drive(mk(op, rs1, rs2, rd, imm, 4'd0));
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("issue_timeout", in_ready, 1);
    @(posedge clk);
  endtask
  task automatic expect_wr(string nm, logic [1:0] a, logic [3:0] d);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      seen = we3 && (a3 == a);
    end
    chk(nm, {we3, a3, d3}, {1'b1, a, d});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int stalls, wr;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_d3", d3, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd1, 4'd5,  4'd5));
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd0, 4'd3,  4'd3));
    vq.push_back(mk(3'd0, 2'd0, 2'd0, 2'd2, 4'd0,  4'd6));
    vq.push_back(mk(3'd1, 2'd0, 2'd1, 2'd3, 4'd0,  4'd14));
    vq.push_back(mk(3'd6, 2'd0, 2'd0, 2'd0, 4'd0,  4'd0));
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd1, 4'd9,  4'd9));
    vq.push_back(mk(3'd6, 2'd1, 2'd1, 2'd1, 4'd0,  4'd0));
    vq.push_back(mk(3'd2, 2'd1, 2'd1, 2'd2, 4'd0,  4'd9));
    vq.push_back(mk(3'd3, 2'd1, 2'd0, 2'd3, 4'd0,  4'd11));
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd2, 4'd1,  4'd1));
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd2, 4'd2,  4'd2));
    vq.push_back(mk(3'd0, 2'd2, 2'd2, 2'd3, 4'd0,  4'd4));
    vq.push_back(mk(3'd1, 2'd1, 2'd2, 2'd0, 4'd0,  4'd7));
    vq.push_back(mk(3'd3, 2'd0, 2'd0, 2'd1, 4'd0,  4'd7));
    vq.push_back(mk(3'd7, 2'd0, 2'd0, 2'd2, 4'd0,  4'd0));
    run_vecs();
    @(negedge clk);
    chk("retire_table", retire_cnt, 15);
    issue(3'd4, 2'd0, 2'd0, 2'd0, 4'd3);
    issue(3'd4, 2'd0, 2'd0, 2'd1, 4'd5);
    issue(3'd5, 2'd0, 2'd1, 2'd2, 4'd0);
    @(negedge clk);
    drive(mk(3'd0, 2'd2, 2'd0, 2'd3, 4'd0, 4'd0));
    stalls = 0;
    while (!in_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", stalls, 3);
    @(posedge clk);
    expect_wr("mul_3x5", 2'd2, 4'd15);
    expect_wr("add_after_mul", 2'd3, 4'd2);
    issue(3'd4, 2'd0, 2'd0, 2'd0, 4'd7);
    issue(3'd4, 2'd0, 2'd0, 2'd1, 4'd6);
    issue(3'd5, 2'd0, 2'd1, 2'd2, 4'd0);
    expect_wr("mul_7x6", 2'd2, 4'd10);
    issue(3'd4, 2'd0, 2'd0, 2'd3, 4'd4);
    issue(3'd5, 2'd0, 2'd1, 2'd2, 4'd0);
    @(negedge clk);
    chk("li_before_rst", {we3, a3, d3}, {1'b1, 2'd3, 4'd4});
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_we3", we3, 0);
    chk("rst_mid_retire", retire_cnt, 0);
    chk("rst_mid_wr", {a3, d3}, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0;
    repeat (8) begin
      @(negedge clk);
      if (we3) wr++;
    end
    chk("aborted_mul_writes", wr, 0);
    chk("retire_after_abort", retire_cnt, 0);
    vq.delete();
    vq.push_back(mk(3'd4, 2'd0, 2'd0, 2'd0, 4'd1, 4'd1));
    for (int i = 1; i < 20; i++) vq.push_back(mk(3'd0, 2'd0, 2'd0, 2'd0, 4'd0, 4'((1 << i) & 15)));
    run_vecs();
    @(negedge clk);
    chk("retire_chain", retire_cnt, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
